papertape_punch_iop: RTL

- Paper tape punch device controller for IOP 0, device 5, sitting beside the tape reader controller on the shared IOP memory bus.
- When selected by the IOP, it fetches the command doubleword through the pointer at word X'20' and reads the addressed byte string out of memory.
- It streams those bytes to the punch mechanism over a valid/ready byte interface, then posts completion status to word X'21'.
- It is the memory-to-device counterpart of the tape reader, which moves data device-to-memory.

---
 rtl/papertape_punch_iop.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/papertape_punch_iop.sv
// Paper tape punch controller (IOP 0, device 5): fetches a command doubleword, streams its byte string to the punch, posts status.
// Optional leader of LEADER_LEN zero bytes before the data, enabled by defining PUNCH_LEADER_EN.
module papertape_punch_iop #(
  parameter logic [16:0] CMD_PTR_ADDR = 17'h20,
  parameter logic [16:0] STATUS_ADDR  = 17'h21,
  parameter logic [31:0] STATUS_WORD  = 32'h0E000000,
  parameter int unsigned LEADER_LEN   = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         active,
  output logic [15:31] memory_address,
  input  logic [0:31]  memory_data_in,
  output logic [0:31]  memory_data_out,
  output logic [0:3]   wr_enables,
  input  logic [0:2]   iop_func,
  input  logic [21:31] iop_device,
  output logic [0:1]   iop_cc,
  output logic [0:7]   punch_data,
  output logic         punch_valid,
  input  logic         punch_ready
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH_PTR,
    S_CDW0,
    S_CDW1,
    S_LOAD,
    S_EMIT,
    S_STATUS,
    S_DONE
`ifdef PUNCH_LEADER_EN
    , S_LEADER
`endif
  } state_t;

  state_t       state;
  logic [15:33] p;
  logic [15:33] ba;
  logic [15:0]  count;
  logic         wr_en;
  logic [0:1]   cc;
  logic [0:7]   lane_byte;

`ifdef PUNCH_LEADER_EN
  localparam int unsigned LW = (LEADER_LEN > 1) ? $clog2(LEADER_LEN) : 1;
  logic [LW-1:0] lcnt;
`endif

  // Device routing happens upstream, so the device field is only carried through.
  logic unused_ok;
  assign unused_ok = ^{iop_device, (LEADER_LEN != 0)};

  always_comb begin
    lane_byte = '0;
    unique case (p[32:33])
      2'd0: lane_byte = memory_data_in[0:7];
      2'd1: lane_byte = memory_data_in[8:15];
      2'd2: lane_byte = memory_data_in[16:23];
      2'd3: lane_byte = memory_data_in[24:31];
      default: lane_byte = '0;
    endcase
  end

  assign memory_address  = active ? ((state == S_STATUS) ? STATUS_ADDR : p[15:31]) : 'z;
  assign memory_data_out = active ? (wr_en ? STATUS_WORD : '0) : 'z;
  assign wr_enables      = active ? {4{wr_en}} : 'z;
  assign iop_cc          = active ? cc : 'z;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      p           <= '0;
      ba          <= '0;
      count       <= '0;
      punch_data  <= '0;
      punch_valid <= 1'b0;
      wr_en       <= 1'b0;
      cc          <= 2'b01;
`ifdef PUNCH_LEADER_EN
      lcnt        <= '0;
`endif
    end else if (!active) begin
      // Abort: any byte still offered is dropped and no status is posted.
      state       <= S_IDLE;
      punch_valid <= 1'b0;
      count       <= '0;
      wr_en       <= 1'b0;
      cc          <= 2'b01;
    end else begin
      wr_en <= 1'b0;
      unique case (state)
        S_IDLE: begin
          cc <= 2'b01;
          if (iop_func == 3'b000) begin
            p     <= {CMD_PTR_ADDR, 2'b00};
            state <= S_FETCH_PTR;
          end
        end
        S_FETCH_PTR: begin
          p     <= {memory_data_in[16:31], 3'b000};
          state <= S_CDW0;
        end
        S_CDW0: begin
          ba    <= memory_data_in[13:31];
          p     <= p + 19'd4;
          state <= S_CDW1;
        end
        S_CDW1: begin
          count <= memory_data_in[16:31];
          p     <= ba;
          if (memory_data_in[16:31] == 16'd0) begin
            wr_en <= 1'b1;
            state <= S_STATUS;
          end else begin
`ifdef PUNCH_LEADER_EN
            punch_data  <= '0;
            punch_valid <= 1'b1;
            lcnt        <= '0;
            state       <= S_LEADER;
`else
            state <= S_LOAD;
`endif
          end
        end
`ifdef PUNCH_LEADER_EN
        S_LEADER: begin
          if (punch_ready) begin
            if (lcnt == LW'(LEADER_LEN - 1)) begin
              punch_valid <= 1'b0;
              state       <= S_LOAD;
            end else begin
              lcnt <= lcnt + 1'b1;
            end
          end
        end
`endif
        S_LOAD: begin
          punch_data  <= lane_byte;
          punch_valid <= 1'b1;
          state       <= S_EMIT;
        end
        S_EMIT: begin
          if (punch_ready) begin
            punch_valid <= 1'b0;
            p           <= p + 19'd1;
            count       <= count - 16'd1;
            if (count == 16'd1) begin
              wr_en <= 1'b1;
              state <= S_STATUS;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_STATUS: begin
          cc    <= 2'b00;
          state <= S_DONE;
        end
        S_DONE: begin
          cc <= 2'b00;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
